// File: rtl/i2c_read_collector_pkg.sv
// Shared types and constants for the I2C read collector: state encoding,
// FIFO entry layout and timer sizing.
package i2c_read_collector_pkg;

  localparam int unsigned C_DATA_W       = 8;
  localparam int unsigned C_ENTRY_W      = 17;
  localparam int unsigned C_TIMER_W      = 12;
  localparam int unsigned C_DROP_W       = 8;
  localparam int unsigned C_TIMEOUT_DFLT = 4095;

  typedef enum logic [2:0] {
    C_ST_IDLE  = 3'd0,
    C_ST_START = 3'd1,
    C_ST_WAIT1 = 3'd2,
    C_ST_WAIT2 = 3'd3,
    C_ST_PUSH  = 3'd4
  } state_t;

  // One buffered sample: producing domain plus {first byte, second byte}.
  typedef struct packed {
    logic                tag;
    logic [C_DATA_W-1:0] hi;
    logic [C_DATA_W-1:0] lo;
  } entry_t;

endpackage

// File: rtl/i2c_read_collector_if.sv
// Reader-side and consumer-side signals of the collector.
// master = collector, slave = reader/consumer environment.
interface i2c_read_collector_if;
  import i2c_read_collector_pkg::*;

  logic                  start;
  logic [C_DATA_W-1:0]   rd_data;
  logic                  valid;
  logic                  done;
  logic [2*C_DATA_W-1:0] out_data;
  logic                  out_domain;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output start, out_data, out_domain, out_valid,
    input  rd_data, valid, done, out_ready
  );

  modport slave (
    input  start, out_data, out_domain, out_valid,
    output rd_data, valid, done, out_ready
  );

endinterface

// File: rtl/i2c_read_collector_fifo.sv
// Synchronous show-ahead FIFO of collector entries; head is the entry at the
// read pointer, valid whenever o_empty is low.
module i2c_read_collector_fifo
  import i2c_read_collector_pkg::*;
#(
  parameter  int unsigned DEPTH  = 4,
  localparam int unsigned ADDR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W  = ADDR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_en,
  input  entry_t           i_wr_data,
  input  logic             i_rd_en,
  output entry_t           o_rd_data,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  entry_t              r_mem [DEPTH];
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic                w_do_wr;
  logic                w_do_rd;

  assign w_do_wr = i_wr_en && !o_full;
  assign w_do_rd = i_rd_en && !o_empty;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_count   = r_count;
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);

endmodule

// File: rtl/i2c_read_collector.sv
// Sequences one two-byte read per request, packs the bytes with the request's
// domain tag and queues them; the head is presented only to its own domain.
module i2c_read_collector
  import i2c_read_collector_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = C_TIMEOUT_DFLT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_domain,
  input  logic                i_req,
  output logic                o_busy,
  output logic                o_err_timeout,
  output logic                o_err_abort,
  output logic [C_DROP_W-1:0] o_drop_cnt,
  i2c_read_collector_if.master bus
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_tag;
  logic [C_DATA_W-1:0]   r_hi;
  logic [C_DATA_W-1:0]   r_lo;
  logic [C_TIMER_W-1:0]  r_timer;
  logic                  r_err_tmo;
  logic                  r_err_abort;
  logic [C_DROP_W-1:0]   r_drop;

  entry_t                w_head;
  logic [CNT_W-1:0]      w_count;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_space;
  logic                  w_in_wait;
  logic                  w_dom_chg;
  logic                  w_tmo;
  logic                  w_out_valid;
  logic                  w_pop;
  logic                  w_unused_done;

  logic w_start, w_busy, w_latch_tag, w_timer_clr, w_timer_inc;
  logic w_ld_hi, w_ld_lo, w_clr_data, w_set_tmo, w_set_abort, w_push, w_drop;

  assign w_space   = (w_count < CNT_W'(FIFO_DEPTH));
  assign w_in_wait = (r_state == C_ST_WAIT1) || (r_state == C_ST_WAIT2);
  assign w_dom_chg = (i_domain != r_tag);
  assign w_tmo     = (r_timer >= C_TIMER_W'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst) r_state <= C_ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Domain change beats valid, valid beats timeout.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      C_ST_IDLE:  if (i_req && w_space) w_state_nxt = C_ST_START;
      C_ST_START: w_state_nxt = C_ST_WAIT1;
      C_ST_WAIT1: begin
        if (w_dom_chg)      w_state_nxt = C_ST_IDLE;
        else if (bus.valid) w_state_nxt = C_ST_WAIT2;
        else if (w_tmo)     w_state_nxt = C_ST_IDLE;
      end
      C_ST_WAIT2: begin
        if (w_dom_chg)      w_state_nxt = C_ST_IDLE;
        else if (bus.valid) w_state_nxt = C_ST_PUSH;
        else if (w_tmo)     w_state_nxt = C_ST_IDLE;
      end
      C_ST_PUSH:  w_state_nxt = C_ST_IDLE;
      default:    w_state_nxt = C_ST_IDLE;
    endcase
  end

  always_comb begin
    w_start     = 1'b0;
    w_busy      = 1'b0;
    w_latch_tag = 1'b0;
    w_timer_clr = 1'b0;
    w_timer_inc = 1'b0;
    w_ld_hi     = 1'b0;
    w_ld_lo     = 1'b0;
    w_clr_data  = 1'b0;
    w_set_tmo   = 1'b0;
    w_set_abort = 1'b0;
    w_push      = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      C_ST_IDLE:  w_drop = i_req && !w_space;
      C_ST_START: begin
        w_start     = 1'b1;
        w_busy      = 1'b1;
        w_latch_tag = 1'b1;
        w_timer_clr = 1'b1;
      end
      C_ST_WAIT1, C_ST_WAIT2: begin
        w_busy = 1'b1;
        if (w_dom_chg) begin
          w_set_abort = 1'b1;
          w_clr_data  = 1'b1;
        end else if (bus.valid) begin
          w_ld_hi = (r_state == C_ST_WAIT1);
          w_ld_lo = (r_state == C_ST_WAIT2);
        end else if (w_tmo) begin
          w_set_tmo  = 1'b1;
          w_clr_data = 1'b1;
        end else begin
          w_timer_inc = 1'b1;
        end
      end
      C_ST_PUSH: begin
        w_busy = 1'b1;
        w_push = !w_full;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag       <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_timer     <= '0;
      r_err_tmo   <= 1'b0;
      r_err_abort <= 1'b0;
      r_drop      <= '0;
    end else begin
      if (w_latch_tag) r_tag <= i_domain;
      if (w_timer_clr)      r_timer <= '0;
      else if (w_timer_inc) r_timer <= r_timer + C_TIMER_W'(1);
      if (w_clr_data) begin
        r_hi <= '0;
        r_lo <= '0;
      end else begin
        if (w_ld_hi) r_hi <= bus.rd_data;
        if (w_ld_lo) r_lo <= bus.rd_data;
      end
      if (w_set_tmo)   r_err_tmo   <= 1'b1;
      if (w_set_abort) r_err_abort <= 1'b1;
      if (w_drop && (r_drop != '1)) r_drop <= r_drop + C_DROP_W'(1);
    end
  end

  i2c_read_collector_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_push),
    .i_wr_data ({r_tag, r_hi, r_lo}),
    .i_rd_en   (w_pop),
    .o_rd_data (w_head),
    .o_count   (w_count),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  // Head is hidden from, and cannot be popped by, a foreign domain.
  assign w_out_valid = !w_empty && (w_head.tag == i_domain);
  assign w_pop       = w_out_valid && bus.out_ready;

  assign bus.start      = w_start;
  assign bus.out_valid  = w_out_valid;
  assign bus.out_data   = w_out_valid ? {w_head.hi, w_head.lo} : '0;
  assign bus.out_domain = w_out_valid ? w_head.tag : 1'b0;

  assign o_busy        = w_busy;
  assign o_err_timeout = r_err_tmo;
  assign o_err_abort   = r_err_abort;
  assign o_drop_cnt    = r_drop;

  assign w_unused_done = bus.done;

endmodule
